uart_tx_fifo: RTL and testbench

Parametrised UART transmitter, the next generation of the team's fixed-format Tx unit. It adds a TX FIFO with a valid/ready write port and a programmable baud divisor. Frame format is selected at run time: 5–DATA_W data bits, none/odd/even parity, 1 or 2 stop bits. It sits between the bus-side register block and the serial pin.

---
 rtl/uart_tx_fifo.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a TX FIFO (valid/ready write port) and run-time frame
// format: 5..DATA_W data bits, none/odd/even parity, 1 or 2 stop bits.
// The frame configuration is captured when a byte is popped, so changes to
// the configuration inputs during a frame only affect the next frame.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | line high; pops the FIFO head when non-empty
// START  | start bit (0) for one bit period
// DATA   | data bits, LSB first, len_q bit periods
// PARITY | parity bit for one bit period (only if parity enabled)
// STOP   | stop bit(s) (1) for one or two bit periods
module uart_tx_fifo #(
   parameter int DATA_W     = 8,
   parameter int DIV_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clock,
   input  logic                          rst,
   input  logic [DIV_W-1:0]              baud_div,
   input  logic [3:0]                    data_len,
   input  logic [1:0]                    parity_type,
   input  logic                          stop_bits,
   input  logic                          wr_valid,
   input  logic [DATA_W-1:0]             wr_data,
   output logic                          wr_ready,
   output logic                          data_out,
   output logic                          tx_active,
   output logic                          tx_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int               PTR_W   = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]   DEPTH_L = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [3:0]       LEN_MAX = 4'(DATA_W);
   localparam logic [3:0]       LEN_MIN = 4'd5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t state, state_nxt;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W:0]    level;
   logic              push, pop;

   logic [DIV_W-1:0]  div_q;
   logic [3:0]        len_q;
   logic              par_en_q;
   logic              par_bit_q;
   logic              stop2_q;
   logic [DATA_W-1:0] shift_q;

   logic [DIV_W-1:0]  baud_cnt;
   logic [3:0]        bit_idx;
   logic              stop_idx;
   logic              bit_end;

   logic [3:0]        len_c;
   logic [DATA_W-1:0] len_mask;
   logic [DATA_W-1:0] head_masked;

   // wr_ready is based on the pre-pop level, so a push while full is refused
   // even in the cycle the head is popped.
   assign wr_ready = (level < DEPTH_L);
   assign push     = wr_valid && wr_ready;
   assign pop      = (state == S_IDLE) && (level != '0);
   assign fifo_level = level;
   assign bit_end  = (baud_cnt == div_q);

   // Clamp the requested length into 5..DATA_W and build the data-bit mask.
   always_comb begin
      len_c = data_len;
      if (data_len < LEN_MIN) len_c = LEN_MIN;
      else if (data_len > LEN_MAX) len_c = LEN_MAX;
      len_mask = '0;
      for (int i = 0; i < DATA_W; i++) begin
         len_mask[i] = (4'(i) < len_c);
      end
      head_masked = mem[rd_ptr] & len_mask;
   end

   // FIFO storage; contents need no reset since level gates every read.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (level != '0) state_nxt = S_START;
         S_START:  if (bit_end) state_nxt = S_DATA;
         S_DATA:   if (bit_end && (bit_idx == len_q - 4'd1))
                      state_nxt = par_en_q ? S_PARITY : S_STOP;
         S_PARITY: if (bit_end) state_nxt = S_STOP;
         S_STOP:   if (bit_end && (stop_idx == stop2_q)) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Frame datapath: config capture on pop, baud counter, bit/stop indices.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         div_q     <= DIV_W'(1);
         len_q     <= LEN_MAX;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         stop2_q   <= 1'b0;
         shift_q   <= '0;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
      end else begin
         if (state == S_IDLE || bit_end) baud_cnt <= '0;
         else                            baud_cnt <= baud_cnt + 1'b1;

         if (pop) begin
            div_q     <= (baud_div == '0) ? DIV_W'(1) : baud_div;
            len_q     <= len_c;
            par_en_q  <= (parity_type == 2'b01) || (parity_type == 2'b10);
            par_bit_q <= (^head_masked) ^ (parity_type == 2'b01);
            stop2_q   <= stop_bits;
            shift_q   <= head_masked;
         end

         if (state == S_START) bit_idx <= '0;
         else if (state == S_DATA && bit_end) begin
            bit_idx <= bit_idx + 4'd1;
            shift_q <= shift_q >> 1;
         end

         if (state != S_STOP) stop_idx <= 1'b0;
         else if (bit_end)    stop_idx <= 1'b1;
      end
   end

   // Outputs decoded from the current state.
   always_comb begin
      data_out  = 1'b1;
      tx_active = (state != S_IDLE);
      tx_done   = (state == S_STOP) && bit_end && (stop_idx == stop2_q);
      case (state)
         S_START:  data_out = 1'b0;
         S_DATA:   data_out = shift_q[0];
         S_PARITY: data_out = par_bit_q;
         default:  data_out = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based frame model predicts every output on
// every cycle, and directed frames pin the model with hand-computed values.
module tb_uart_tx_fifo;

   logic        clock;
   logic        rst;
   logic [15:0] baud_div;
   logic [3:0]  data_len;
   logic [1:0]  parity_type;
   logic        stop_bits;
   logic        wr_valid;
   logic [7:0]  wr_data;
   logic        wr_ready;
   logic        data_out;
   logic        tx_active;
   logic        tx_done;
   logic [2:0]  fifo_level;

   uart_tx_fifo #(.DATA_W(8), .DIV_W(16), .FIFO_DEPTH(4)) dut (
      .clock       (clock),
      .rst         (rst),
      .baud_div    (baud_div),
      .data_len    (data_len),
      .parity_type (parity_type),
      .stop_bits   (stop_bits),
      .wr_valid    (wr_valid),
      .wr_data     (wr_data),
      .wr_ready    (wr_ready),
      .data_out    (data_out),
      .tx_active   (tx_active),
      .tx_done     (tx_done),
      .fifo_level  (fifo_level)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail < 40)
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic line;
      logic act;
      logic done;
   } smp_t;

   localparam smp_t IDLE_S = '{line: 1'b1, act: 1'b0, done: 1'b0};

   smp_t       cur;
   smp_t       wave[$];
   logic [7:0] mq[$];
   bit         m_acc;
   int         n_acc;

   // Expand one byte into its per-clock line waveform using the frame rules.
   function automatic void build_frame(input logic [7:0] d);
      int   per, len, total;
      int   bl[$];
      bit   p;
      smp_t s;
      per = (baud_div == 16'd0) ? 2 : int'(baud_div) + 1;
      len = int'(data_len);
      if (len < 5) len = 5;
      if (len > 8) len = 8;
      p = 1'b0;
      bl.push_back(0);
      for (int i = 0; i < len; i++) begin
         bl.push_back(int'(d[i]));
         p = p ^ d[i];
      end
      if (parity_type == 2'b01) bl.push_back(int'(!p));
      else if (parity_type == 2'b10) bl.push_back(int'(p));
      bl.push_back(1);
      if (stop_bits) bl.push_back(1);
      total = bl.size() * per;
      for (int j = 0; j < total; j++) begin
         s.line = bl[j / per][0];
         s.act  = 1'b1;
         s.done = (j == total - 1);
         wave.push_back(s);
      end
   endfunction

   // Model step on each rising edge; reset clears queue and frame.
   always @(posedge clock or negedge rst) begin
      if (!rst) begin
         mq.delete();
         wave.delete();
         cur   = IDLE_S;
         m_acc = 1'b0;
      end else begin
         m_acc = wr_valid && (mq.size() < 4);
         if (wave.size() > 0) cur = wave.pop_front();
         else if (!cur.act && mq.size() > 0) begin
            build_frame(mq.pop_front());
            cur = wave.pop_front();
         end else cur = IDLE_S;
         if (m_acc) begin
            mq.push_back(wr_data);
            n_acc++;
         end
      end
   end

   // Compare every output against the model, away from the active edge.
   always @(negedge clock) begin
      chk("data_out",   data_out,   cur.line);
      chk("tx_active",  tx_active,  cur.act);
      chk("tx_done",    tx_done,    cur.done);
      chk("wr_ready",   wr_ready,   (mq.size() < 4));
      chk("fifo_level", fifo_level, mq.size());
   end

   int dones = 0;
   always @(negedge clock) if (tx_done) dones++;

   // ---------------- directed stimulus ----------------
   task automatic push_byte(input logic [7:0] d);
      wr_data  = d;
      wr_valid = 1'b1;
      @(negedge clock);
      wr_valid = 1'b0;
   endtask

   task automatic set_cfg(input logic [15:0] dv, input logic [3:0] ln,
                          input logic [1:0] pt, input logic sb);
      baud_div    = dv;
      data_len    = ln;
      parity_type = pt;
      stop_bits   = sb;
   endtask

   // Wait for a frame and sample the line at the first clock of each bit.
   task automatic capture(input int per, output logic [15:0] bits, output int done_at);
      int t;
      bits    = '1;
      done_at = -1;
      t       = 0;
      while (!tx_active && t < 100) begin
         @(negedge clock);
         t++;
      end
      chk("frame_start", tx_active, 1);
      for (int k = 0; k < 14 * per; k++) begin
         if ((k % per) == 0 && (k / per) < 16) bits[k / per] = data_out;
         if (tx_done && done_at < 0) done_at = k;
         @(negedge clock);
      end
   endtask

   logic [15:0] bits;
   int          done_at;
   int          sent, first_stall, max_lvl, d0;
   bit          act_seen;

   initial begin
      rst      = 1'b0;
      wr_valid = 1'b0;
      wr_data  = 8'h00;
      set_cfg(16'd3, 4'd8, 2'b00, 1'b0);
      n_acc    = 0;
      repeat (3) @(negedge clock);
      rst = 1'b1;

      // idle after reset
      repeat (100) @(negedge clock);
      chk("idle_line",  data_out,   1);
      chk("idle_level", fifo_level, 0);
      chk("idle_ready", wr_ready,   1);

      // 8N1 0x55: 0,1,0,1,0,1,0,1,0,1 with 4 clocks per bit
      push_byte(8'h55);
      capture(4, bits, done_at);
      chk("8n1_bits", bits[9:0], 10'h2AA);
      chk("8n1_done", done_at, 39);

      // 8E1 0x07 -> parity 1
      set_cfg(16'd3, 4'd8, 2'b10, 1'b0);
      push_byte(8'h07);
      capture(4, bits, done_at);
      chk("8e1_par",  bits[9], 1);
      chk("8e1_stop", bits[10], 1);
      chk("8e1_done", done_at, 43);

      // 8O1 0x07 -> parity 0
      set_cfg(16'd3, 4'd8, 2'b01, 1'b0);
      push_byte(8'h07);
      capture(4, bits, done_at);
      chk("8o1_07_par", bits[9], 0);

      // 8O1 0x03 -> parity 1
      push_byte(8'h03);
      capture(4, bits, done_at);
      chk("8o1_03_par", bits[9], 1);

      // 7E2 0xFF -> 7 data ones, parity 1, two stop periods
      set_cfg(16'd3, 4'd7, 2'b10, 1'b1);
      push_byte(8'hFF);
      capture(4, bits, done_at);
      chk("7e2_start", bits[0], 0);
      chk("7e2_data",  bits[7:1], 7'h7F);
      chk("7e2_par",   bits[8], 1);
      chk("7e2_done",  done_at, 43);

      // 5-bit 0xE0 -> five zero data bits, one stop, 7 bit periods
      set_cfg(16'd3, 4'd5, 2'b00, 1'b0);
      push_byte(8'hE0);
      capture(4, bits, done_at);
      chk("5n1_bits", bits[6:0], 7'h40);
      chk("5n1_done", done_at, 27);

      // baud_div 0 acts as 1, data_len 15 clamps to 8, parity 11 is none, 2 stops
      set_cfg(16'd0, 4'd15, 2'b11, 1'b1);
      push_byte(8'h3C);
      capture(2, bits, done_at);
      chk("clamp_bits", bits[10:0], 11'h678);
      chk("clamp_done", done_at, 21);

      // FIFO full and back-to-back
      set_cfg(16'd1, 4'd8, 2'b00, 1'b0);
      sent        = 0;
      first_stall = -1;
      max_lvl     = 0;
      d0          = dones;
      for (int c = 0; c < 250; c++) begin
         wr_valid = (sent < 6);
         wr_data  = 8'(sent + 1);
         @(negedge clock);
         if (m_acc) sent++;
         if (!wr_ready && first_stall < 0) first_stall = sent;
         if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      end
      wr_valid = 1'b0;
      chk("burst_stall_after", first_stall, 5);
      chk("burst_sent",        sent, 6);
      chk("burst_max_level",   max_lvl, 4);
      chk("burst_dones",       dones - d0, 6);

      // reset during data bit 3 of 0xA5 with two more bytes queued
      set_cfg(16'd3, 4'd8, 2'b00, 1'b0);
      push_byte(8'hA5);
      push_byte(8'h11);
      push_byte(8'h22);
      begin
         int t;
         t = 0;
         while (!tx_active && t < 100) begin
            @(negedge clock);
            t++;
         end
      end
      chk("rst_frame_start", tx_active, 1);
      repeat (17) @(negedge clock);
      chk("rst_pre_line", data_out, 0);
      #2 rst = 1'b0;
      #1;
      chk("rst_async_line",   data_out,   1);
      chk("rst_async_active", tx_active,  0);
      chk("rst_async_done",   tx_done,    0);
      chk("rst_async_level",  fifo_level, 0);
      @(negedge clock);
      @(negedge clock);
      #2 rst = 1'b1;
      d0       = dones;
      act_seen = 1'b0;
      repeat (100) begin
         @(negedge clock);
         if (tx_active) act_seen = 1'b1;
      end
      chk("rst_no_done",   dones - d0, 0);
      chk("rst_no_frames", act_seen, 0);
      chk("rst_level_end", fifo_level, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
